// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
// Holds the branch funct encodings, default sizing for the control bundle,
// forwarding network and load block, and the branch-outcome helper.
package id_ex_pipe_stage_pkg;

  localparam int unsigned DEF_CTRL_WIDTH = 12;
  localparam int unsigned DEF_NUM_FWD    = 3;
  localparam int unsigned DEF_LOAD_LAT   = 1;

  typedef enum logic [2:0] {
    BrBeq  = 3'b000,
    BrBne  = 3'b001,
    BrBlt  = 3'b100,
    BrBge  = 3'b101,
    BrBltu = 3'b110,
    BrBgeu = 3'b111
  } br_funct_e;

  // Branch outcome from precomputed comparisons; keeps this width-independent.
  // Encodings 010 and 011 are undefined and resolve as not taken.
  function automatic logic br_taken(input logic [2:0] funct, input logic eq,
                                    input logic lt_s, input logic lt_u);
    logic taken;
    taken = 1'b0;
    case (funct)
      BrBeq:   taken = eq;
      BrBne:   taken = !eq;
      BrBlt:   taken = lt_s;
      BrBge:   taken = !lt_s;
      BrBltu:  taken = lt_u;
      BrBgeu:  taken = !lt_u;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/id_ex_pipe_stage_fwd_select.sv
// Priority forwarding mux for one source operand.
// Ports:
//   rs        - operand register index (index 0 always reads as zero)
//   rf_data   - register-file read data, used when no source matches
//   fwd_valid - per-source "holds a register write"
//   fwd_ready - per-source "data is final"
//   fwd_rd    - packed destinations, source i at [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   fwd_data  - packed data, source i at [i*REG_WIDTH +: REG_WIDTH]
//   data      - resolved operand value
//   avail     - 0 when the selected source has not produced its data yet
module id_ex_pipe_stage_fwd_select
  import id_ex_pipe_stage_pkg::*;
#(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD        = DEF_NUM_FWD
) (
  input  logic [REG_ADDR_WIDTH-1:0]         rs,
  input  logic [REG_WIDTH-1:0]              rf_data,
  input  logic [NUM_FWD-1:0]                fwd_valid,
  input  logic [NUM_FWD-1:0]                fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [NUM_FWD*REG_WIDTH-1:0]      fwd_data,
  output logic [REG_WIDTH-1:0]              data,
  output logic                              avail
);

  logic found;

  // Source 0 is the youngest write, so the lowest matching index wins.
  always_comb begin
    data  = rf_data;
    avail = 1'b1;
    found = 1'b0;
    if (rs == '0) begin
      data = '0;
    end else begin
      for (int i = 0; i < int'(NUM_FWD); i++) begin
        if (!found && fwd_valid[i] && (fwd_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs)) begin
          found = 1'b1;
          data  = fwd_data[i*REG_WIDTH +: REG_WIDTH];
          avail = fwd_ready[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Decode-to-execute pipeline stage.
// Resolves both operands through the forwarding network, stalls on unready
// forwards and on recent loads, resolves branches in ID and holds the result
// in a valid/ready ID/EX register.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   in_*                         - decoded instruction, valid/ready handshake
//   fwd_*                        - forwarding sources, index 0 highest priority
//   flush                        - squash from a later stage
//   out_*                        - ID/EX register, valid/ready handshake to EX
//   redirect_valid, redirect_pc  - one-cycle taken-branch redirect
//   stall_count                  - saturating count of hazard-stall cycles
module id_ex_pipe_stage
  import id_ex_pipe_stage_pkg::*;
#(
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned CTRL_WIDTH      = DEF_CTRL_WIDTH,
  parameter int unsigned NUM_FWD         = DEF_NUM_FWD,
  parameter int unsigned LOAD_LAT        = DEF_LOAD_LAT,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PC_WIDTH-1:0]               in_pc,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rd,
  input  logic                              in_uses_rs1,
  input  logic                              in_uses_rs2,
  input  logic [REG_WIDTH-1:0]              in_rs1_data,
  input  logic [REG_WIDTH-1:0]              in_rs2_data,
  input  logic [REG_WIDTH-1:0]              in_imm,
  input  logic [CTRL_WIDTH-1:0]             in_ctrl,
  input  logic                              in_is_load,
  input  logic                              in_is_branch,
  input  logic [2:0]                        in_br_funct,
  input  logic [NUM_FWD-1:0]                fwd_valid,
  input  logic [NUM_FWD-1:0]                fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [NUM_FWD*REG_WIDTH-1:0]      fwd_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PC_WIDTH-1:0]               out_pc,
  output logic [REG_WIDTH-1:0]              out_imm,
  output logic [REG_WIDTH-1:0]              out_rs1_data,
  output logic [REG_WIDTH-1:0]              out_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0]         out_rd,
  output logic [CTRL_WIDTH-1:0]             out_ctrl,
  output logic                              out_is_load,
  output logic                              redirect_valid,
  output logic [PC_WIDTH-1:0]               redirect_pc,
  output logic [STALL_CNT_WIDTH-1:0]        stall_count
);

  localparam int unsigned CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  logic [REG_WIDTH-1:0]      rs1_val, rs2_val;
  logic                      rs1_avail, rs2_avail;
  logic [CNT_W-1:0]          blk_cnt;
  logic [REG_ADDR_WIDTH-1:0] blk_rd;
  logic                      rs1_blocked, rs2_blocked;
  logic                      hazard, transfer, taken;

  id_ex_pipe_stage_fwd_select #(
    .REG_WIDTH      (REG_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD        (NUM_FWD)
  ) u_fwd_rs1 (
    .rs        (in_rs1),
    .rf_data   (in_rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (rs1_val),
    .avail     (rs1_avail)
  );

  id_ex_pipe_stage_fwd_select #(
    .REG_WIDTH      (REG_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD        (NUM_FWD)
  ) u_fwd_rs2 (
    .rs        (in_rs2),
    .rf_data   (in_rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (rs2_val),
    .avail     (rs2_avail)
  );

  // A recent load's result is not on any forward path yet; block its readers.
  assign rs1_blocked = (blk_cnt != '0) && (blk_rd != '0) && (in_rs1 == blk_rd);
  assign rs2_blocked = (blk_cnt != '0) && (blk_rd != '0) && (in_rs2 == blk_rd);

  assign hazard = in_valid && ((in_uses_rs1 && (!rs1_avail || rs1_blocked)) ||
                               (in_uses_rs2 && (!rs2_avail || rs2_blocked)));

  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  assign taken = in_is_branch && br_taken(in_br_funct, rs1_val == rs2_val,
                                          $signed(rs1_val) < $signed(rs2_val),
                                          rs1_val < rs2_val);

  // ID/EX register; payload only moves on a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_ctrl     <= '0;
      out_is_load  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_imm      <= in_imm;
      out_rs1_data <= rs1_val;
      out_rs2_data <= rs2_val;
      out_rd       <= in_rd;
      out_ctrl     <= in_ctrl;
      out_is_load  <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Load block, branch redirect and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt        <= '0;
      blk_rd         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_count    <= '0;
    end else begin
      if (in_valid && hazard && !flush && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_WIDTH'(1);
      end
      if (flush) begin
        blk_cnt        <= '0;
        redirect_valid <= 1'b0;
      end else begin
        redirect_valid <= transfer && taken;
        if (transfer && taken) begin
          redirect_pc <= in_pc + PC_WIDTH'(in_imm);
        end
        if (transfer && in_is_load && (in_rd != '0) && (LOAD_LAT > 0)) begin
          blk_cnt <= CNT_W'(LOAD_LAT);
          blk_rd  <= in_rd;
        end else if (blk_cnt != '0) begin
          blk_cnt <= blk_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage (LOAD_LAT = 2).
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the stage kept in this file.
module tb_id_ex_pipe_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_is_load, in_is_branch;
  logic [11:0] in_ctrl;
  logic [2:0]  in_br_funct;
  logic [2:0]  fwd_valid, fwd_ready;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic        flush, out_valid, out_ready, out_is_load, redirect_valid;
  logic [31:0] out_pc, out_imm, out_rs1_data, out_rs2_data, redirect_pc;
  logic [4:0]  out_rd;
  logic [11:0] out_ctrl;
  logic [15:0] stall_count;

  id_ex_pipe_stage #(.LOAD_LAT(LAT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_uses_rs1    (in_uses_rs1),
    .in_uses_rs2    (in_uses_rs2),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_ctrl        (in_ctrl),
    .in_is_load     (in_is_load),
    .in_is_branch   (in_is_branch),
    .in_br_funct    (in_br_funct),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_imm        (out_imm),
    .out_rs1_data   (out_rs1_data),
    .out_rs2_data   (out_rs2_data),
    .out_rd         (out_rd),
    .out_ctrl       (out_ctrl),
    .out_is_load    (out_is_load),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  logic last_rdy;

  // Reference model state.
  bit          m_valid, m_is_load, m_redir;
  logic [31:0] m_pc, m_imm, m_a, m_b, m_redir_pc;
  logic [4:0]  m_rd, m_blk_rd;
  logic [11:0] m_ctrl;
  int          m_stall, m_blk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_is_load = 0; m_redir = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0;
    m_redir_pc = 0; m_rd = 0; m_blk_rd = 0; m_ctrl = 0; m_stall = 0; m_blk = 0;
  endtask

  // Operand value and availability from the forwarding rules.
  task automatic resolve(input logic [4:0] rs, input logic [31:0] rf,
                         output logic [31:0] val, output bit avail);
    bit hit;
    val = rf; avail = 1; hit = 0;
    if (rs == 0) val = 0;
    else
      for (int i = 0; i < 3; i++)
        if (!hit && fwd_valid[i] && fwd_rd[i*5 +: 5] == rs) begin
          hit = 1; val = fwd_data[i*32 +: 32]; avail = fwd_ready[i];
        end
  endtask

  function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic bit blocked(input logic [4:0] rs);
    return m_blk > 0 && m_blk_rd != 0 && rs == m_blk_rd;
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_pc", 64'(out_pc), 64'(m_pc));
    check("out_imm", 64'(out_imm), 64'(m_imm));
    check("out_rs1_data", 64'(out_rs1_data), 64'(m_a));
    check("out_rs2_data", 64'(out_rs2_data), 64'(m_b));
    check("out_rd", 64'(out_rd), 64'(m_rd));
    check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    check("out_is_load", 64'(out_is_load), 64'(m_is_load));
    check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
    check("redirect_pc", 64'(redirect_pc), 64'(m_redir_pc));
    check("stall_count", 64'(stall_count), 64'(m_stall));
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic cycle();
    logic [31:0] a, b;
    bit av1, av2, haz, rdy, xfer, tk;
    @(negedge clk);
    resolve(in_rs1, in_rs1_data, a, av1);
    resolve(in_rs2, in_rs2_data, b, av2);
    haz = in_valid && ((in_uses_rs1 && (!av1 || blocked(in_rs1))) ||
                       (in_uses_rs2 && (!av2 || blocked(in_rs2))));
    rdy = !haz && !flush && (!m_valid || out_ready);
    check("in_ready", 64'(in_ready), 64'(rdy));
    last_rdy = in_ready;
    xfer = in_valid && rdy;
    tk = in_is_branch && ref_taken(in_br_funct, a, b);
    if (in_valid && haz && !flush && m_stall != 65535) m_stall++;
    if (flush) begin
      m_valid = 0; m_blk = 0; m_redir = 0;
    end else begin
      m_redir = xfer && tk;
      if (xfer && tk) m_redir_pc = in_pc + in_imm;
      if (xfer) begin
        m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_a = a; m_b = b;
        m_rd = in_rd; m_ctrl = in_ctrl; m_is_load = in_is_load;
      end else if (out_ready) m_valid = 0;
      if (xfer && in_is_load && in_rd != 0) begin
        m_blk = LAT; m_blk_rd = in_rd;
      end else if (m_blk > 0) m_blk--;
    end
    @(posedge clk);
    #1;
    check_outputs();
    n_vec++;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_ctrl = 0; in_is_load = 0; in_is_branch = 0; in_br_funct = 0;
    fwd_valid = 0; fwd_ready = 3'b111; fwd_rd = 0; fwd_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = 1; in_uses_rs2 = 1; in_is_load = ld; in_is_branch = 0;
    in_rs1_data = 32'h1000 + 32'(rs1); in_rs2_data = 32'h2000 + 32'(rs2);
    in_imm = 32'h4; in_ctrl = 12'(pc);
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset redirect_valid", 64'(redirect_valid), 64'd0);
    check("reset stall_count", 64'(stall_count), 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    cycle();

    // Forward priority: source 0 beats source 1 on the same rd.
    offer(32'h10, 5'd5, 5'd0, 5'd9, 0);
    fwd_valid = 3'b011; fwd_rd = {5'd0, 5'd5, 5'd5};
    fwd_data = {32'h0, 32'hBBBB, 32'hAAAA};
    cycle();
    check("fwd priority", 64'(out_rs1_data), 64'hAAAA);
    idle(); cycle();

    // Unready forward source stalls and counts; release transfers.
    offer(32'h20, 5'd0, 5'd7, 5'd8, 0);
    fwd_valid = 3'b001; fwd_ready = 3'b110; fwd_rd = {10'd0, 5'd7}; fwd_data = 96'h77;
    repeat (3) begin
      cycle();
      check("unready stall", 64'(last_rdy), 64'd0);
    end
    check("stall count 3", 64'(stall_count), 64'd3);
    fwd_ready = 3'b111;
    cycle();
    check("unready release", 64'(out_valid), 64'd1);
    check("unready data", 64'(out_rs2_data), 64'h77);
    idle(); cycle();

    // Load-use: dependent held two cycles, accepted on the third.
    offer(32'h30, 5'd0, 5'd0, 5'd3, 1); cycle();
    offer(32'h34, 5'd3, 5'd0, 5'd4, 0);
    cycle(); check("load-use 1", 64'(last_rdy), 64'd0);
    cycle(); check("load-use 2", 64'(last_rdy), 64'd0);
    cycle(); check("load-use 3", 64'(last_rdy), 64'd1);
    idle(); cycle();
    offer(32'h40, 5'd0, 5'd0, 5'd3, 1); cycle();
    offer(32'h44, 5'd4, 5'd0, 5'd6, 0);
    cycle(); check("load independent", 64'(last_rdy), 64'd1);
    idle(); repeat (2) cycle();

    // Signed vs unsigned branch compare.
    offer(32'h100, 5'd1, 5'd2, 5'd0, 0);
    in_rs1_data = 32'hFFFF_FFFF; in_rs2_data = 32'd1; in_imm = 32'h20;
    in_is_branch = 1; in_br_funct = 3'b100;
    cycle();
    check("blt redirect", 64'(redirect_valid), 64'd1);
    check("blt target", 64'(redirect_pc), 64'h120);
    idle(); cycle();
    check("redirect pulse", 64'(redirect_valid), 64'd0);
    offer(32'h100, 5'd1, 5'd2, 5'd0, 0);
    in_rs1_data = 32'hFFFF_FFFF; in_rs2_data = 32'd1; in_imm = 32'h20;
    in_is_branch = 1; in_br_funct = 3'b110;
    cycle();
    check("bltu no redirect", 64'(redirect_valid), 64'd0);
    idle(); cycle();

    // Backpressure holds the register, release captures next instruction.
    offer(32'h200, 5'd1, 5'd2, 5'd10, 0); out_ready = 0; cycle();
    offer(32'h204, 5'd1, 5'd2, 5'd11, 0); out_ready = 0;
    cycle(); check("bp in_ready", 64'(last_rdy), 64'd0);
    check("bp hold", 64'(out_pc), 64'h200);
    out_ready = 1; cycle();
    check("bp release", 64'(out_pc), 64'h204);
    idle(); cycle();

    // Flush beats a taken branch offered while a load block is live.
    offer(32'h300, 5'd0, 5'd0, 5'd3, 1); cycle();
    offer(32'h304, 5'd0, 5'd0, 5'd0, 0);
    in_is_branch = 1; in_br_funct = 3'b000; flush = 1;
    cycle();
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush redirect", 64'(redirect_valid), 64'd0);
    idle();
    offer(32'h308, 5'd3, 5'd0, 5'd5, 0);
    cycle(); check("flush clears block", 64'(last_rdy), 64'd1);
    idle(); cycle();

    // Asynchronous reset mid-operation, with a load block live.
    offer(32'h400, 5'd0, 5'd0, 5'd3, 1); cycle();
    idle();
    #2 reset_n = 0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset stall", 64'(stall_count), 64'd0);
    check("async reset out_pc", 64'(out_pc), 64'd0);
    model_reset();
    #1 reset_n = 1;
    offer(32'h404, 5'd3, 5'd0, 5'd5, 0);
    cycle(); check("reset clears block", 64'(last_rdy), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_rd        = 5'($urandom_range(0, 7));
      in_uses_rs1  = 1'($urandom);
      in_uses_rs2  = 1'($urandom);
      in_rs1_data  = $urandom;
      in_rs2_data  = ($urandom_range(0, 3) == 0) ? in_rs1_data : $urandom;
      in_imm       = $urandom;
      in_ctrl      = 12'($urandom);
      in_is_load   = ($urandom_range(0, 3) == 0);
      in_is_branch = ($urandom_range(0, 2) == 0);
      in_br_funct  = 3'($urandom);
      fwd_valid    = 3'($urandom);
      fwd_ready    = 3'($urandom) | 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        fwd_rd[i*5 +: 5]    = 5'($urandom_range(0, 7));
        fwd_data[i*32 +: 32] = $urandom;
      end
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised decode-to-execute stage for the pipelined core.
- Takes decoded fields and register-file read data from the decoder.
- Resolves operands through an N-source priority forwarding network.
- Detects load-use hazards with an internal block counter, resolves branches in ID, and holds the result in a valid/ready ID/EX pipeline register.
- Sits between the decoder/register file and the execute stage.

Parameters:
REG_WIDTH, 32, operand/data width
REG_ADDR_WIDTH, 5, register index width
PC_WIDTH, 32, program counter width
CTRL_WIDTH, 12, opaque control bundle carried to EX
NUM_FWD, 3, forwarding sources; index 0 is youngest/highest priority
LOAD_LAT, 1, cycles a load result stays unforwardable after issue; 0 disables the internal block
STALL_CNT_WIDTH, 16, width of the stall performance counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  PC_WIDTH  instruction PC
in_rs1, in_rs2, in_rd  in  REG_ADDR_WIDTH each  register indices
in_uses_rs1, in_uses_rs2  in  1 each  operand actually read
in_rs1_data, in_rs2_data  in  REG_WIDTH each  register-file read data
in_imm  in  REG_WIDTH  sign-extended immediate
in_ctrl  in  CTRL_WIDTH  control bundle
in_is_load, in_is_branch  in  1 each  instruction class
in_br_funct  in  3  BEQ=000 BNE=001 BLT=100 BGE=101 BLTU=110 BGEU=111
fwd_valid  in  NUM_FWD  source i holds a register write
fwd_ready  in  NUM_FWD  source i data is final
fwd_rd  in  NUM_FWD*REG_ADDR_WIDTH  destination of source i
fwd_data  in  NUM_FWD*REG_WIDTH  data of source i
flush  in  1  squash from a later stage
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc, out_imm  out  PC_WIDTH / REG_WIDTH  registered copies
out_rs1_data, out_rs2_data  out  REG_WIDTH each  resolved operands
out_rd  out  REG_ADDR_WIDTH  destination
out_ctrl  out  CTRL_WIDTH  control bundle
out_is_load  out  1  load flag
redirect_valid  out  1  taken-branch redirect, one-cycle pulse
redirect_pc  out  PC_WIDTH  branch target
stall_count  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles

Behaviour:
- Reset: every output register is 0, including out_valid, redirect_valid, stall_count and the load-block counter.
- Operand resolution, combinational, per operand:
  - Index 0 yields 0.
  - Otherwise scan i=0..NUM_FWD-1; the first i with fwd_valid[i] and fwd_rd[i]==rs selects fwd_data[i].
  - If that selected source has fwd_ready[i]=0, the operand is not available.
  - No match selects the register-file data.
- hazard is asserted when in_valid and, for any used operand, one of the following holds:
  - the operand is not available, or
  - the load-block counter is nonzero and the operand index equals the blocked rd (non-zero).
- Handshake:
  - in_ready = !hazard && !flush && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready; the ID/EX register captures all fields plus resolved operands.
  - If out_ready && out_valid with no transfer, out_valid clears.
  - The register holds its contents while out_valid && !out_ready.
- Load block:
  - On transfer of a load with in_rd!=0 and LOAD_LAT>0, counter <= LOAD_LAT and blocked rd <= in_rd.
  - Otherwise a nonzero counter decrements every cycle.
  - A new load overrides the old block.
- Branch:
  - Compare the resolved operands: signed for BLT/BGE, unsigned for BLTU/BGEU.
  - On transfer of a taken branch, the next cycle redirect_valid=1 for exactly one cycle and redirect_pc = in_pc + in_imm (low PC_WIDTH bits, wraps).
  - Undefined funct values count as not taken.
- Flush, synchronous, highest priority:
  - The next cycle out_valid=0, the counter is 0, and redirect_valid=0.
  - No transfer happens in the flush cycle.
- stall_count increments each cycle with in_valid && hazard && !flush and saturates at all-ones.
- Reset asserted mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared header risc_v_defines.vh gets:
  - branch funct encodings
  - CTRL_WIDTH default
  - NUM_FWD and LOAD_LAT defaults
- Sub-module fwd_select: one operand's priority forwarding mux plus its availability flag, instantiated twice.

Test Plan:
- Forward priority: fwd_valid=3'b011, both rd=5, data0=0xAAAA, data1=0xBBBB, rs1=5 -> out_rs1_data=0xAAAA one cycle after transfer.
- Unready source: fwd_valid[0]=1, fwd_ready[0]=0, rd=7, rs2=7 used -> in_ready=0, stall_count increments each cycle; raise fwd_ready -> transfer next cycle.
- Load-use with LOAD_LAT=2: load rd=3 transfers, then dependent rs1=3 -> held 2 cycles, accepted on the 3rd; an independent rs1=4 instead is accepted immediately.
- Branch: BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> redirect_valid pulses 1 cycle with redirect_pc=0x120; the same operands with BLTU -> no redirect.
- Backpressure: out_ready=0 with a valid held -> in_ready=0 and outputs stable; out_ready=1 -> next instruction captured the same cycle.
- Flush in the cycle a taken branch and a load are offered -> no transfer, out_valid=0, redirect_valid=0, counter=0 the next cycle.
